autotype_sequencer: RTL and testbench

- Scripted boot and keystroke sequencer for the Orao top level on boards without buttons or a PS/2 keyboard.
- Replaces the fixed free-running autotype counter.
- Walks a script held in an external synchronous ROM. Each entry asserts the computer's reset, holds one onboard key, or idles, for a programmed number of ticks.
- Drives the n_reset and key_* inputs of the orao instance.

---
 rtl/autotype_sequencer_if.sv | 26 ++
 rtl/autotype_sequencer.sv | 176 +++++++++++++++++
 tb/tb_autotype_sequencer.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/autotype_sequencer_if.sv
// Script-ROM and computer-control bundle between the autotype sequencer
// (master modport) and its environment: ROM, Orao core and control logic (slave modport).
interface autotype_sequencer_if #(
  parameter int ADDR_W = 5,
  parameter int NKEYS  = 3
);
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] script_addr;
  logic [15:0]       script_data;
  logic              n_reset_out;
  logic [NKEYS-1:0]  keys;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    input  start, abort, script_data,
    output script_addr, n_reset_out, keys, busy, done, err
  );

  modport slave (
    output start, abort, script_data,
    input  script_addr, n_reset_out, keys, busy, done, err
  );
endinterface

// File: rtl/autotype_sequencer.sv
// Scripted boot/keystroke sequencer: walks a synchronous script ROM and drives
// the Orao reset and onboard key inputs for programmed numbers of ticks.
module autotype_sequencer #(
  parameter int TICK_CYCLES = 2500000,
  parameter int ADDR_W      = 5,
  parameter int NKEYS       = 3,
  parameter int AUTO_START  = 1
) (
  input logic                  clk,
  input logic                  reset,
  autotype_sequencer_if.master bus
);
  localparam int              TW        = $clog2(TICK_CYCLES);
  localparam logic [TW-1:0]   TICK_LAST = TW'(TICK_CYCLES - 1);
  localparam logic [5:0]      KEY_LIMIT = 6'(NKEYS);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LATCH = 3'd2;
  localparam logic [2:0] S_EXEC  = 3'd3;
  localparam logic [2:0] S_NEXT  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [2:0] OP_END  = 3'd0;
  localparam logic [2:0] OP_RST  = 3'd1;
  localparam logic [2:0] OP_KEY  = 3'd2;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [TW-1:0]     tick_q, tick_d;
  logic [7:0]        dur_q, dur_d;
  logic              ent_rst_q, ent_rst_d;
  logic [NKEYS-1:0]  ent_keys_q, ent_keys_d;
  logic              n_reset_q, n_reset_d;
  logic [NKEYS-1:0]  keys_q, keys_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              auto_q, auto_d;

  logic [2:0]        rom_op;
  logic [4:0]        rom_idx;
  logic [7:0]        rom_dur;
  logic              rom_illegal;
  logic [NKEYS-1:0]  key_onehot;
  logic              in_busy_state;
  logic              exec_drive;

  assign rom_op  = bus.script_data[15:13];
  assign rom_idx = bus.script_data[12:8];
  assign rom_dur = bus.script_data[7:0];

  always_comb begin
    key_onehot = '0;
    for (int k = 0; k < NKEYS; k++) begin
      key_onehot[k] = (rom_idx == 5'(k));
    end
  end

  assign rom_illegal   = rom_op[2] | ((rom_op == OP_KEY) & ({1'b0, rom_idx} >= KEY_LIMIT));
  assign in_busy_state = (state_q != S_IDLE) && (state_q != S_DONE);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    tick_d     = tick_q;
    dur_d      = dur_q;
    ent_rst_d  = ent_rst_q;
    ent_keys_d = ent_keys_q;
    done_d     = done_q;
    err_d      = err_q;
    auto_d     = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (!bus.abort && (bus.start || (state_q == S_IDLE && auto_q))) begin
          state_d = S_FETCH;
          addr_d  = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        if (rom_illegal) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else if (rom_op == OP_END) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (rom_dur == 8'd0) begin
          state_d = S_NEXT;
        end else begin
          state_d    = S_EXEC;
          tick_d     = '0;
          dur_d      = rom_dur;
          ent_rst_d  = (rom_op == OP_RST);
          ent_keys_d = (rom_op == OP_KEY) ? key_onehot : '0;
        end
      end
      S_EXEC: begin
        if (tick_q == TICK_LAST) begin
          tick_d = '0;
          dur_d  = dur_q - 8'd1;
          if (dur_q == 8'd1) begin
            state_d = S_NEXT;
          end
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      S_NEXT: begin
        // The last ROM slot ends the script instead of wrapping back to 0.
        if (addr_q == '1) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (in_busy_state && bus.abort) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
      err_d   = err_q;
    end

    // Entry outputs lag EXEC by one cycle, which yields the 3-cycle release gap.
    exec_drive = (state_q == S_EXEC) && !bus.abort;
    n_reset_d  = exec_drive ? !ent_rst_q : 1'b1;
    keys_d     = exec_drive ? ent_keys_q : '0;
    busy_d     = (state_d == S_FETCH) || (state_d == S_LATCH) ||
                 (state_d == S_EXEC)  || (state_d == S_NEXT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      tick_q     <= '0;
      dur_q      <= '0;
      ent_rst_q  <= 1'b0;
      ent_keys_q <= '0;
      n_reset_q  <= 1'b0;
      keys_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      auto_q     <= (AUTO_START != 0);
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      tick_q     <= tick_d;
      dur_q      <= dur_d;
      ent_rst_q  <= ent_rst_d;
      ent_keys_q <= ent_keys_d;
      n_reset_q  <= n_reset_d;
      keys_q     <= keys_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      auto_q     <= auto_d;
    end
  end

  assign bus.script_addr = addr_q;
  assign bus.n_reset_out = n_reset_q;
  assign bus.keys        = keys_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
endmodule

// File: tb/tb_autotype_sequencer.sv
// Self-checking bench for autotype_sequencer: directed script table, hand-written
// abort/restart/reset sequences, and random scripts against a timeline model.
module tb_autotype_sequencer;
  localparam int TICK   = 4;
  localparam int ADDR_W = 2;
  localparam int NKEYS  = 3;

  typedef logic [3:0][15:0] script_t;

  typedef struct {
    script_t rom;
    bit      viaReset;
    int      doneCyc;
    int      errV;
    int      nresLow;
    int      keyCyc;
    int      keyOr;
  } vec_t;

  typedef struct packed {
    logic       n_reset;
    logic [2:0] keys;
    logic       busy;
    logic       done;
    logic       err;
  } obs_t;

  logic    clk = 1'b0;
  logic    reset;
  script_t romImage;
  int      checks = 0;
  int      failures = 0;
  obs_t    expQ[$];
  vec_t    vecs[7];

  autotype_sequencer_if #(.ADDR_W(ADDR_W), .NKEYS(NKEYS)) bus ();

  autotype_sequencer #(
    .TICK_CYCLES(TICK),
    .ADDR_W     (ADDR_W),
    .NKEYS      (NKEYS),
    .AUTO_START (1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.master)
  );

  always #5 clk = ~clk;

  // Synchronous script ROM: data follows the address by one clock.
  always @(posedge clk) bus.script_data <= romImage[bus.script_addr];

  function automatic logic [15:0] ent(input int op, input int idx, input int d);
    return {3'(op), 5'(idx), 8'(d)};
  endfunction

  function automatic obs_t mkObs(input logic n, input logic [2:0] k, input logic b,
                                 input logic d, input logic e);
    obs_t o;
    o.n_reset = n;
    o.keys    = k;
    o.busy    = b;
    o.done    = d;
    o.err     = e;
    return o;
  endfunction

  function automatic obs_t observe();
    return mkObs(bus.n_reset_out, bus.keys, bus.busy, bus.done, bus.err);
  endfunction

  function automatic vec_t mkVec(input logic [15:0] e0, input logic [15:0] e1,
                                 input logic [15:0] e2, input logic [15:0] e3,
                                 input bit viaReset, input int doneCyc, input int errV,
                                 input int nresLow, input int keyCyc, input int keyOr);
    vec_t v;
    v.rom[0]   = e0;
    v.rom[1]   = e1;
    v.rom[2]   = e2;
    v.rom[3]   = e3;
    v.viaReset = viaReset;
    v.doneCyc  = doneCyc;
    v.errV     = errV;
    v.nresLow  = nresLow;
    v.keyCyc   = keyCyc;
    v.keyOr    = keyOr;
    return v;
  endfunction

  // Timeline model: every legal entry is 3 released busy cycles followed by
  // D*TICK cycles of its outputs; END/illegal finish right after the ROM read.
  function automatic void buildModel(input script_t s);
    obs_t idleBusy = mkObs(1'b1, 3'b000, 1'b1, 1'b0, 1'b0);
    obs_t doneOk   = mkObs(1'b1, 3'b000, 1'b0, 1'b1, 1'b0);
    obs_t doneErr  = mkObs(1'b1, 3'b000, 1'b0, 1'b1, 1'b1);
    expQ.delete();
    for (int a = 0; a < 4; a++) begin
      int   op  = int'(s[a][15:13]);
      int   idx = int'(s[a][12:8]);
      int   d   = int'(s[a][7:0]);
      obs_t act = idleBusy;
      expQ.push_back(idleBusy);
      expQ.push_back(idleBusy);
      if (op >= 4 || (op == 2 && idx >= NKEYS)) begin
        expQ.push_back(doneErr);
        return;
      end
      if (op == 0) begin
        expQ.push_back(doneOk);
        return;
      end
      expQ.push_back(idleBusy);
      if (op == 1) act.n_reset = 1'b0;
      if (op == 2) act.keys = 3'(1 << idx);
      for (int i = 0; i < d * TICK; i++) expQ.push_back(act);
    end
    expQ.push_back(doneOk);
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic a);
    bus.start = s;
    bus.abort = a;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
  endtask

  task automatic runVector(input vec_t v, input int n);
    int   doneCyc = -1;
    int   nresLow = 0;
    int   keyCyc  = 0;
    int   keyOr   = 0;
    int   errAt   = -1;
    int   busyAt  = -1;
    romImage = v.rom;
    if (v.viaReset) begin
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
    end
    for (int c = 0; c < 200; c++) begin
      applyStimulus(!v.viaReset && c == 0, 1'b0);
      if (!bus.n_reset_out) nresLow++;
      if (bus.keys != 3'b000) keyCyc++;
      keyOr = keyOr | int'(bus.keys);
      if (bus.done) begin
        doneCyc = c;
        errAt   = int'(bus.err);
        busyAt  = int'(bus.busy);
        break;
      end
    end
    checkOutput($sformatf("vec%0d.doneCycle", n), doneCyc, v.doneCyc);
    checkOutput($sformatf("vec%0d.err", n), errAt, v.errV);
    checkOutput($sformatf("vec%0d.busyAtDone", n), busyAt, 0);
    checkOutput($sformatf("vec%0d.nResetLowCycles", n), nresLow, v.nresLow);
    checkOutput($sformatf("vec%0d.keyCycles", n), keyCyc, v.keyCyc);
    checkOutput($sformatf("vec%0d.keyMask", n), keyOr, v.keyOr);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    script_t s;
    int      op;
    int      qsize;
    obs_t    expv;

    vecs[0] = mkVec(ent(1,0,2), ent(2,1,1), ent(0,0,0), ent(0,0,0), 1'b1, 20, 0, 8, 4, 3'b010);
    vecs[1] = mkVec(ent(2,0,1), ent(2,0,1), ent(0,0,0), ent(0,0,0), 1'b0, 16, 0, 0, 8, 3'b001);
    vecs[2] = mkVec(ent(3,0,0), ent(2,2,1), ent(0,0,0), ent(0,0,0), 1'b0, 12, 0, 0, 4, 3'b100);
    vecs[3] = mkVec(ent(3,0,1), ent(5,0,1), ent(0,0,0), ent(0,0,0), 1'b0,  9, 1, 0, 0, 3'b000);
    vecs[4] = mkVec(ent(3,0,1), ent(3,0,1), ent(3,0,1), ent(3,0,1), 1'b0, 28, 0, 0, 0, 3'b000);
    vecs[5] = mkVec(ent(2,3,1), ent(0,0,0), ent(0,0,0), ent(0,0,0), 1'b0,  2, 1, 0, 0, 3'b000);
    vecs[6] = mkVec(ent(0,0,0), ent(3,0,1), ent(3,0,1), ent(3,0,1), 1'b0,  2, 0, 0, 0, 3'b000);

    reset     = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    romImage  = vecs[0].rom;
    #3;
    checkOutput("resetOutputs", int'(observe()), int'(mkObs(1'b0, 3'b000, 1'b0, 1'b0, 1'b0)));
    checkOutput("resetAddr", int'(bus.script_addr), 0);

    for (int n = 0; n < 7; n++) runVector(vecs[n], n);

    // Illegal key index leaves err and done set; the next start clears both.
    romImage = vecs[5].rom;
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("illegalKeyErr", int'(observe()), int'(mkObs(1'b1, 3'b000, 1'b0, 1'b1, 1'b1)));
    for (int a = 0; a < 4; a++) romImage[a] = ent(3, 0, 200);
    applyStimulus(1'b1, 1'b0);
    checkOutput("startClearsErr", int'(observe()), int'(mkObs(1'b1, 3'b000, 1'b1, 1'b0, 1'b0)));
    for (int c = 0; c < 9; c++) applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("abortInExec", int'(observe()), int'(mkObs(1'b1, 3'b000, 1'b0, 1'b0, 1'b0)));
    for (int c = 0; c < 3; c++) applyStimulus(1'b0, 1'b0);
    checkOutput("idleAfterAbort", int'(bus.busy), 0);
    applyStimulus(1'b1, 1'b1);
    checkOutput("startAbortSameCycle", int'(bus.busy), 0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("startAbortStaysIdle", int'(bus.busy), 0);

    // A start pulse while running must not restart the script.
    for (int a = 0; a < 4; a++) romImage[a] = ent(2, 1, 200);
    applyStimulus(1'b1, 1'b0);
    for (int c = 0; c < 4; c++) applyStimulus(1'b0, 1'b0);
    checkOutput("keyHeld", int'(bus.keys), 3'b010);
    applyStimulus(1'b1, 1'b0);
    for (int c = 0; c < 4; c++) begin
      checkOutput($sformatf("startWhileBusy%0d", c), int'(observe()),
                  int'(mkObs(1'b1, 3'b010, 1'b1, 1'b0, 1'b0)));
      applyStimulus(1'b0, 1'b0);
    end
    applyStimulus(1'b0, 1'b1);
    checkOutput("abortKeyRelease", int'(observe()), int'(mkObs(1'b1, 3'b000, 1'b0, 1'b0, 1'b0)));

    // Reset asserted between clock edges clears outputs immediately.
    for (int a = 0; a < 4; a++) romImage[a] = ent(2, 0, 200);
    applyStimulus(1'b1, 1'b0);
    for (int c = 0; c < 5; c++) applyStimulus(1'b0, 1'b0);
    checkOutput("keyBeforeReset", int'(bus.keys), 3'b001);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("asyncResetOutputs", int'(observe()), int'(mkObs(1'b0, 3'b000, 1'b0, 1'b0, 1'b0)));
    checkOutput("asyncResetAddr", int'(bus.script_addr), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0);
    checkOutput("autoStartAfterReset", int'(bus.busy), 1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("abortAutoStart", int'(bus.busy), 0);

    for (int r = 0; r < 20; r++) begin
      for (int a = 0; a < 4; a++) begin
        op = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(1, 3));
        s[a] = ent(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end
      romImage = s;
      buildModel(s);
      qsize = expQ.size();
      for (int c = 0; c < qsize + 2; c++) begin
        applyStimulus(c == 0, 1'b0);
        expv = (c < qsize) ? expQ[c] : expQ[qsize - 1];
        checkOutput($sformatf("rand%0d.cycle%0d", r, c), int'(observe()), int'(expv));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
